// File: rtl/atcbmc300_ds_rdata_buf_pkg.sv
// Shared constants and types for the BMC300 downstream R-channel buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atcbmc300_ds_rdata_buf_pkg;

    // Slave-id width carried on mst_rsid / self_id.
    localparam int SID_W  = 5;
    // Low RID bits that select the destination master.
    localparam int MIDX_W = 4;

    // AXI RRESP encodings.
    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // FWD: route the head beat to its master. DROP: drain the rest of a dead burst.
    typedef enum logic {
        ST_FWD  = 1'b0,
        ST_DROP = 1'b1
    } rbuf_state_e;

endpackage

// File: rtl/atcbmc300_sync_fifo.sv
// Generic registered synchronous FIFO with full/empty flags.
// Latency: 1 cycle from push to the entry being visible at rd_dat.
// Backpressure: a push while full is ignored, even if a pop happens in the same cycle.
//
// Ports: aclk/areset clock and async active-high reset; push/wr_dat write side;
//        pop/rd_dat read side (rd_dat is the head entry); full/empty status.
module atcbmc300_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Storage is cleared so the head data reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= wr_dat;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/atcbmc300_ds_rdata_buf.sv
// Slave-side R-channel buffer: beat FIFO, per-master routing, burst drop mode, outstanding counter.
// Latency: 1 cycle from ds_rvalid&ds_rready to the beat at the head / slv_rvalid.
// Backpressure: ds_rready=~full; a stalled master stalls the head; dead-master bursts are drained.
//
// Ports: aclk/areset clock and async active-high reset; self_id this slave's index;
//        mst_rready/mst_rsid/mst_connect per-master status; ds_* slave R channel in;
//        slv_rvalid/slv_read_data/slv_rid head beat toward the master muxes;
//        addr_outstanding_en/outstanding_ready/outstanding_cnt burst accounting;
//        drop_beat pulse per discarded beat.
module atcbmc300_ds_rdata_buf
    import atcbmc300_ds_rdata_buf_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int ID_WIDTH          = 4,
    parameter int NUM_MST           = 16,
    parameter int BUF_DEPTH         = 2,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [SID_W-1:0]                       self_id,
    input  logic [NUM_MST-1:0]                     mst_rready,
    input  logic [SID_W*NUM_MST-1:0]               mst_rsid,
    input  logic [NUM_MST-1:0]                     mst_connect,
    input  logic [DATA_WIDTH-1:0]                  ds_rdata,
    input  logic [1:0]                             ds_rresp,
    input  logic [ID_WIDTH+3:0]                    ds_rid,
    input  logic                                   ds_rlast,
    input  logic                                   ds_rvalid,
    output logic                                   ds_rready,
    output logic                                   slv_rvalid,
    output logic [DATA_WIDTH+2:0]                  slv_read_data,
    output logic [ID_WIDTH+3:0]                    slv_rid,
    input  logic                                   addr_outstanding_en,
    output logic                                   outstanding_ready,
    output logic [$clog2(OUTSTANDING_DEPTH+1)-1:0] outstanding_cnt,
    output logic                                   drop_beat
);

    localparam int RID_W = ID_WIDTH + 4;
    localparam int ENT_W = RID_W + 2 + 1 + DATA_WIDTH;
    localparam int CNT_W = $clog2(OUTSTANDING_DEPTH + 1);

    // FIFO entry layout: {rid, rresp, rlast, rdata}.
    logic [ENT_W-1:0]  wr_dat;
    logic [ENT_W-1:0]  head_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [RID_W-1:0]  head_rid;
    logic              head_rlast;
    logic [MIDX_W-1:0] head_idx;

    logic              idx_conn;
    logic [SID_W-1:0]  idx_rsid;
    logic              idx_rdy;
    logic              elig;
    logic              dead;
    logic              active;
    logic              fwd_pop;
    logic              completion;
    logic              ar_acc;

    rbuf_state_e       state;

    assign wr_dat    = {ds_rid, ds_rresp, ds_rlast, ds_rdata};
    assign ds_rready = ~fifo_full;
    assign push      = ds_rvalid & ds_rready;

    atcbmc300_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (push),
        .wr_dat (wr_dat),
        .pop    (pop),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head_rid      = head_dat[ENT_W-1 -: RID_W];
    assign head_rlast    = head_dat[DATA_WIDTH];
    assign head_idx      = head_rid[MIDX_W-1:0];
    assign slv_rid       = head_rid;
    assign slv_read_data = head_dat[DATA_WIDTH+2:0];

    // Per-master lookup of the head's destination. An index at or above
    // NUM_MST matches no entry, so it reads back as disconnected (dead).
    always_comb begin
        idx_conn = 1'b0;
        idx_rsid = '0;
        idx_rdy  = 1'b0;
        for (int m = 0; m < NUM_MST; m++) begin
            if (head_idx == MIDX_W'(m)) begin
                idx_conn = mst_connect[m];
                idx_rsid = mst_rsid[SID_W*m +: SID_W];
                idx_rdy  = mst_rready[m];
            end
        end
    end

    assign dead = ~idx_conn;
    // A connected master looking at another slave only stalls the head.
    assign elig = idx_conn & (idx_rsid == self_id);

    // Beats are held back until at least one burst is open.
    assign active     = ~fifo_empty & (outstanding_cnt != '0);
    assign slv_rvalid = (state == ST_FWD) & active & ~dead;
    assign drop_beat  = active & ((state == ST_DROP) | dead);
    assign fwd_pop    = slv_rvalid & elig & idx_rdy;
    assign pop        = fwd_pop | drop_beat;
    assign completion = pop & head_rlast;

    // Completion bypass lets a full counter take a new AR in the same cycle.
    assign outstanding_ready = (outstanding_cnt < CNT_W'(OUTSTANDING_DEPTH)) |
                               ((outstanding_cnt == CNT_W'(OUTSTANDING_DEPTH)) & completion);
    // An AR offered while not ready is ignored, which saturates the count.
    assign ar_acc = addr_outstanding_en & outstanding_ready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            outstanding_cnt <= '0;
        end else begin
            case ({ar_acc, completion})
                2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
                2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

    // Once a non-last beat of a burst is dropped the remainder is drained
    // regardless of later connect changes, keeping the burst atomic.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_FWD;
        end else if (drop_beat) begin
            case (state)
                ST_FWD:  if (!head_rlast) state <= ST_DROP;
                ST_DROP: if (head_rlast)  state <= ST_FWD;
                default: state <= ST_FWD;
            endcase
        end
    end

    a_no_ar_overflow: assert property (@(posedge aclk) disable iff (areset)
        addr_outstanding_en |-> outstanding_ready);

endmodule
